dma_desc_mfifo: RTL and testbench
=================================

# dma_desc_mfifo

Multi-channel descriptor queue for the Venus DMA CSR path, generalising the single descriptor FIFO to NUM_CH independent per-channel queues.
- Each queue is a circular buffer of {descriptor, last} entries.
- A round-robin arbiter drains the queues into one registered valid/ready output.
- Arbitration is chain-atomic: once a channel starts a descriptor chain, it owns the output until its last=1 descriptor is delivered.
- The block sits between the CSR descriptor-write logic and the DMA engine's descriptor fetch stage, and adds per-channel flush, occupancy counts, almost-full flags and write-drop reporting.

## Interface
Parameters:
- NUM_CH, 4: number of channels; must be ≥1.
- DEPTH, 16: entries per channel; power of 2, ≥2.
- DESC_W, 96: descriptor width, packing {SRC, DST, LEN} at 32 bits each.
- AFULL_TH, DEPTH-2: almost-full threshold; must satisfy 1..DEPTH.
- Derived (not overridable): CH_W = max(1, $clog2(NUM_CH)); CNT_W = $clog2(DEPTH)+1.

Ports:
- clk, in, 1: clock. Single clock domain; reset is synchronous and active-high.
- rst, in, 1: synchronous, active-high reset.
- wr_en_i, in, 1: push request.
- wr_ch_i, in, CH_W: target channel.
- wr_desc_i, in, DESC_W: descriptor to push.
- wr_last_i, in, 1: marks the last descriptor of a chain.
- flush_i, in, NUM_CH: per-channel flush, one bit per channel.
- out_valid_o, out, 1: output register holds a descriptor.
- out_ready_i, in, 1: consumer accepts the output.
- out_desc_o, out, DESC_W: output descriptor.
- out_last_o, out, 1: output last flag.
- out_ch_o, out, CH_W: source channel of the output.
- count_o, out, NUM_CH*CNT_W: per-channel occupancy; channel c occupies bits [c*CNT_W +: CNT_W].
- empty_o, full_o, afull_o, out, NUM_CH each: per-channel status flags.
- wr_drop_o, out, 1: one-cycle pulse signalling a rejected push.

## Operation
**Per-channel storage**
- Read/write pointers are $clog2(DEPTH)+1 bits with a wrap bit.
- empty when pointers are equal; full when low bits are equal and wrap bits differ.
- count = wr_ptr − rd_ptr, modulo 2^CNT_W.
- afull = (count ≥ AFULL_TH).
- Flags are derived from registered pointers.

**Push**
- Accepted when wr_en_i=1, wr_ch_i<NUM_CH, and the channel is not full at the start of the cycle.
- A same-cycle pop does not make room for the push.
- A rejected push (full or out-of-range channel) raises wr_drop_o in the following cycle; queue state is unchanged.

**Output register**
- Loads when out_valid_o=0 or (out_valid_o & out_ready_i), provided some channel is eligible.
- Loading pops the head of the granted channel.
- If nothing is eligible, out_valid_o clears on the handshake.

**Arbiter**
- State: rr_ptr (CH_W bits), lock (1 bit), lock_ch (CH_W bits).
- Unlocked: grant the first non-empty channel at or after rr_ptr, modulo NUM_CH.
- Locked: only lock_ch is eligible. If lock_ch is empty, the output stalls; other channels are not served.
- On pop with last=0: lock←1, lock_ch←granted channel.
- On pop with last=1: lock←0, rr_ptr←(granted channel+1) mod NUM_CH.

**Flush (flush_i[c]=1)**
- Channel c pointers are reset to 0 at the next edge.
- A same-cycle push to c is discarded with no wr_drop_o pulse.
- If lock_ch=c, lock←0.
- If the output register holds a channel-c descriptor and no handshake occurs this cycle, out_valid_o←0.
- A same-cycle handshake wins: the descriptor counts as delivered.
- A flushed channel is not eligible to load in the flush cycle.

**Reset** clears everything: pointers, rr_ptr=0, lock=0.

## Timing
- Reset values:
  - out_valid_o=0, out_desc_o=0, out_last_o=0, out_ch_o=0, wr_drop_o=0.
  - count_o=0, empty_o all 1, full_o all 0, afull_o all 0.
- Push-to-output latency: push accepted in cycle N → count/empty update in N+1 → out_valid_o=1 in N+2 (empty queue, idle output).
- Sustained throughput: 1 descriptor/cycle while out_ready_i=1 and eligible data exists.
- out_desc_o, out_last_o and out_ch_o stay stable while out_valid_o=1 and out_ready_i=0.
- wr_drop_o: registered, high exactly one cycle per rejected push.
- Rst asserted mid-chain or mid-stall: every register reaches its reset value at that edge; partially queued chains are lost.

## Test plan
- **Basic push/drain:** push 3 descriptors on ch2 (last=0,0,1) with out_ready_i=1 → out_valid_o first high 2 cycles after the first push; outputs in order with out_ch_o=2; count_o[ch2] returns to 0.
- **Chain-atomic round robin:** ch0 holds {A(last=0), B(last=1)}; ch1 holds {C(last=1)} with B pushed after C → output order A, C-stall-free?, no: A, then stall until B arrives, then B, C.
- **Full and drop:** DEPTH=16; push 17 to ch1 with out_ready_i=0 → full_o[1]=1, afull_o[1]=1 from count 14, one wr_drop_o pulse, count_o[ch1]=16.
- **Flush:** ch3 locked mid-chain with 4 queued; flush_i[3] for 1 cycle with no handshake → count_o[ch3]=0, out_valid_o drops, lock released, ch0 data served next.
- **Backpressure hold:** out_ready_i=0 for 5 cycles with out_valid_o=1 → out_desc_o unchanged; release → next descriptor follows on the following cycle.
- **Reset mid-operation:** rst asserted with 3 channels non-empty → all status outputs at reset values the next cycle; a push on ch0 is visible on the output 2 cycles later.

Source files
------------

// File: rtl/dma_desc_mfifo.sv
// dma_desc_mfifo
//   Per-channel descriptor queues drained by a chain-atomic round-robin
//   arbiter into a single registered valid/ready output.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   wr_en_i         : push request for channel wr_ch_i
//   wr_ch_i         : target channel of the push
//   wr_desc_i       : descriptor {SRC, DST, LEN}
//   wr_last_i       : last descriptor of a chain
//   flush_i         : per-channel flush, one bit per channel
//   out_valid_o     : output register holds a descriptor
//   out_ready_i     : consumer accepts the output
//   out_desc_o      : output descriptor
//   out_last_o      : output last flag
//   out_ch_o        : source channel of the output descriptor
//   count_o         : per-channel occupancy, channel c at [c*CNT_W +: CNT_W]
//   empty_o, full_o, afull_o : per-channel status flags
//   wr_drop_o       : one-cycle pulse for a rejected push
//
// Handshake: a descriptor transfers on every rising edge where
// out_valid_o=1 and out_ready_i=1. While out_valid_o=1 and out_ready_i=0
// the output payload is held stable; out_valid_o only drops without a
// transfer when the held descriptor's channel is flushed.
module dma_desc_mfifo #(
    parameter  int NUM_CH   = 4,
    parameter  int DEPTH    = 16,
    parameter  int DESC_W   = 96,
    parameter  int AFULL_TH = DEPTH - 2,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [CH_W-1:0]         wr_ch_i,
    input  logic [DESC_W-1:0]       wr_desc_i,
    input  logic                    wr_last_i,
    input  logic [NUM_CH-1:0]       flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DESC_W-1:0]       out_desc_o,
    output logic                    out_last_o,
    output logic [CH_W-1:0]         out_ch_o,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic [NUM_CH-1:0]       empty_o,
    output logic [NUM_CH-1:0]       full_o,
    output logic [NUM_CH-1:0]       afull_o,
    output logic                    wr_drop_o
);

    localparam int AW = CNT_W - 1;

    // Storage entries are {descriptor, last}
    logic [DESC_W:0]    mem [NUM_CH][DEPTH];
    logic [CNT_W-1:0]   wr_ptr [NUM_CH];
    logic [CNT_W-1:0]   rd_ptr [NUM_CH];
    logic [CNT_W-1:0]   cnt [NUM_CH];

    logic [NUM_CH-1:0]  empty, full, elig;
    logic               wr_in_range, push_ok, drop_d;
    logic               load_en, any_elig, pop;
    logic [CH_W-1:0]    grant, rr_next;
    logic [DESC_W:0]    head;

    // Arbiter state
    logic [CH_W-1:0]    rr_ptr;
    logic               lock;
    logic [CH_W-1:0]    lock_ch;

    // A channel index can only be out of range when NUM_CH is not a power of 2
    if (NUM_CH == (1 << CH_W)) begin : g_all_in_range
        assign wr_in_range = 1'b1;
    end else begin : g_range_check
        assign wr_in_range = (wr_ch_i < CH_W'(NUM_CH));
    end

    // Status flags come from registered pointers only
    always_comb begin
        count_o = '0;
        empty   = '0;
        full    = '0;
        afull_o = '0;
        elig    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt[c]   = wr_ptr[c] - rd_ptr[c];
            empty[c] = (wr_ptr[c] == rd_ptr[c]);
            full[c]  = (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]) &&
                       (wr_ptr[c][AW] != rd_ptr[c][AW]);
            afull_o[c] = (int'(cnt[c]) >= AFULL_TH);
            count_o[c*CNT_W +: CNT_W] = cnt[c];
            // A locked chain owns the output; a channel being flushed never loads
            elig[c] = !empty[c] && !flush_i[c] && (!lock || (lock_ch == CH_W'(c)));
        end
    end

    assign empty_o = empty;
    assign full_o  = full;

    // Push decision uses start-of-cycle fullness, so a same-cycle pop never
    // makes room. A push into a channel being flushed is silently discarded.
    always_comb begin
        push_ok = 1'b0;
        drop_d  = 1'b0;
        if (wr_en_i) begin
            if (!wr_in_range) begin
                drop_d = 1'b1;
            end else if (!flush_i[wr_ch_i]) begin
                push_ok = !full[wr_ch_i];
                drop_d  = full[wr_ch_i];
            end
        end
    end

    // Round-robin search starting at rr_ptr; when locked only lock_ch is eligible
    always_comb begin : arb_grant
        int j;
        j        = 0;
        grant    = '0;
        any_elig = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = (int'(rr_ptr) + i) % NUM_CH;
            if (!any_elig && elig[j]) begin
                any_elig = 1'b1;
                grant    = CH_W'(j);
            end
        end
    end

    assign load_en = !out_valid_o || out_ready_i;
    assign pop     = load_en && any_elig;
    assign head    = mem[grant][rd_ptr[grant][AW-1:0]];
    assign rr_next = (int'(grant) == NUM_CH - 1) ? '0 : grant + CH_W'(1);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ch_i][wr_ptr[wr_ch_i][AW-1:0]] <= {wr_desc_i, wr_last_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (flush_i[c]) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                end else begin
                    if (push_ok && (wr_ch_i == CH_W'(c))) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    if (pop && (grant == CH_W'(c)))       rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            out_desc_o  <= '0;
            out_last_o  <= 1'b0;
            out_ch_o    <= '0;
            wr_drop_o   <= 1'b0;
            rr_ptr      <= '0;
            lock        <= 1'b0;
            lock_ch     <= '0;
        end else begin
            wr_drop_o <= drop_d;

            if (load_en) begin
                out_valid_o <= any_elig;
                if (pop) begin
                    out_desc_o <= head[DESC_W:1];
                    out_last_o <= head[0];
                    out_ch_o   <= grant;
                end
            end else if (flush_i[out_ch_o]) begin
                // Held descriptor's channel flushed without a transfer: withdraw it
                out_valid_o <= 1'b0;
            end

            // A pop can never come from a flushed channel, so the flush
            // release of the lock only matters when nothing pops.
            if (pop) begin
                if (head[0]) begin
                    lock   <= 1'b0;
                    rr_ptr <= rr_next;
                end else begin
                    lock    <= 1'b1;
                    lock_ch <= grant;
                end
            end else if (lock && flush_i[lock_ch]) begin
                lock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_desc_mfifo.sv
// tb_dma_desc_mfifo
//   Directed bench for dma_desc_mfifo with default parameters
//   (NUM_CH=4, DEPTH=16, DESC_W=96, AFULL_TH=14).
module tb_dma_desc_mfifo;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [95:0]   wr_desc;
    logic          wr_last;
    logic [3:0]    flush;
    logic          out_valid;
    logic          out_ready;
    logic [95:0]   out_desc;
    logic          out_last;
    logic [1:0]    out_ch;
    logic [19:0]   count;
    logic [3:0]    empty, full, afull;
    logic          wr_drop;

    int checks = 0;
    int errors = 0;

    dma_desc_mfifo dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_ch_i    (wr_ch),
        .wr_desc_i  (wr_desc),
        .wr_last_i  (wr_last),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_desc_o (out_desc),
        .out_last_o (out_last),
        .out_ch_o   (out_ch),
        .count_o    (count),
        .empty_o    (empty),
        .full_o     (full),
        .afull_o    (afull),
        .wr_drop_o  (wr_drop)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [95:0] mk(input int n);
        logic [31:0] v;
        v = n;
        return {32'hA000_0000 | v, 32'hB000_0000 | v, 32'h0000_1000 | v};
    endfunction

    function automatic logic [4:0] cnt(input int c);
        return count[c*5 +: 5];
    endfunction

    task automatic set_push(input logic [1:0] ch, input logic [95:0] d, input logic l);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_desc = d;
        wr_last = l;
    endtask

    task automatic clr_push();
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_desc = '0;
        wr_last = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; clr_push(); flush = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", out_valid); end
        checks++; if (out_desc !== 96'h0) begin errors++; $display("FAIL rst_desc got %0h exp 0", out_desc); end
        checks++; if (count !== 20'h0) begin errors++; $display("FAIL rst_count got %0h exp 0", count); end
        checks++; if (empty !== 4'hF) begin errors++; $display("FAIL rst_empty got %0h exp f", empty); end
        checks++; if (full !== 4'h0 || afull !== 4'h0) begin errors++; $display("FAIL rst_full_afull got %0h/%0h exp 0/0", full, afull); end
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %0h exp 0", wr_drop); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        set_push(2, mk(1), 1'b0); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1 got %0h exp 0", out_valid); end
        checks++; if (cnt(2) !== 5'd1) begin errors++; $display("FAIL basic_cnt1 got %0d exp 1", cnt(2)); end
        set_push(2, mk(2), 1'b0); tick();
        checks++; if (out_valid !== 1'b1 || out_desc !== mk(1) || out_ch !== 2'd2 || out_last !== 1'b0) begin
            errors++; $display("FAIL basic_d1 got v%0h %0h ch%0d l%0h exp v1 %0h ch2 l0", out_valid, out_desc, out_ch, out_last, mk(1)); end
        set_push(2, mk(3), 1'b1); tick();
        checks++; if (out_valid !== 1'b1 || out_desc !== mk(2) || out_ch !== 2'd2) begin
            errors++; $display("FAIL basic_d2 got v%0h %0h ch%0d exp v1 %0h ch2", out_valid, out_desc, out_ch, mk(2)); end
        clr_push(); tick();
        checks++; if (out_valid !== 1'b1 || out_desc !== mk(3) || out_last !== 1'b1) begin
            errors++; $display("FAIL basic_d3 got v%0h %0h l%0h exp v1 %0h l1", out_valid, out_desc, out_last, mk(3)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_done got %0h exp 0", out_valid); end
        checks++; if (cnt(2) !== 5'd0 || empty !== 4'hF) begin errors++; $display("FAIL basic_cnt0 got %0d/%0h exp 0/f", cnt(2), empty); end
    endtask

    task automatic test_chain();
        out_ready = 1'b1;
        set_push(0, mk(10), 1'b0); tick();          // A on ch0
        set_push(1, mk(11), 1'b1); tick();          // C on ch1
        checks++; if (out_valid !== 1'b1 || out_desc !== mk(10) || out_ch !== 2'd0) begin
            errors++; $display("FAIL chain_a got v%0h %0h ch%0d exp v1 %0h ch0", out_valid, out_desc, out_ch, mk(10)); end
        clr_push(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chain_stall1 got %0h exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || cnt(1) !== 5'd1) begin
            errors++; $display("FAIL chain_stall2 got v%0h cnt1 %0d exp v0 cnt1 1", out_valid, cnt(1)); end
        set_push(0, mk(12), 1'b1); tick();          // B on ch0
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chain_stall3 got %0h exp 0", out_valid); end
        clr_push(); tick();
        checks++; if (out_valid !== 1'b1 || out_desc !== mk(12) || out_ch !== 2'd0 || out_last !== 1'b1) begin
            errors++; $display("FAIL chain_b got v%0h %0h ch%0d l%0h exp v1 %0h ch0 l1", out_valid, out_desc, out_ch, out_last, mk(12)); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_desc !== mk(11) || out_ch !== 2'd1) begin
            errors++; $display("FAIL chain_c got v%0h %0h ch%0d exp v1 %0h ch1", out_valid, out_desc, out_ch, mk(11)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chain_done got %0h exp 0", out_valid); end
    endtask

    task automatic test_full_drop();
        out_ready = 1'b0;
        set_push(0, mk(20), 1'b1); tick();          // occupy the output with a ch0 descriptor
        clr_push(); tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
            errors++; $display("FAIL full_hold got v%0h ch%0d exp v1 ch0", out_valid, out_ch); end
        for (int i = 1; i <= 17; i++) begin
            set_push(1, mk(100 + i), 1'b0); tick();
            if (i == 13) begin
                checks++; if (afull[1] !== 1'b0) begin errors++; $display("FAIL full_afull13 got %0h exp 0", afull[1]); end
            end
            if (i == 14) begin
                checks++; if (afull[1] !== 1'b1 || cnt(1) !== 5'd14) begin
                    errors++; $display("FAIL full_afull14 got %0h cnt %0d exp 1 cnt 14", afull[1], cnt(1)); end
            end
            if (i == 16) begin
                checks++; if (full[1] !== 1'b1 || wr_drop !== 1'b0) begin
                    errors++; $display("FAIL full_16 got full %0h drop %0h exp 1/0", full[1], wr_drop); end
            end
            if (i == 17) begin
                checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL full_drop got %0h exp 1", wr_drop); end
            end
        end
        clr_push(); tick();
        checks++; if (wr_drop !== 1'b0 || cnt(1) !== 5'd16) begin
            errors++; $display("FAIL full_after got drop %0h cnt %0d exp 0 cnt 16", wr_drop, cnt(1)); end
        // push into a full channel during its flush: discarded without a drop pulse
        set_push(1, mk(200), 1'b0); flush = 4'b0010; tick();
        flush = '0; clr_push();
        checks++; if (cnt(1) !== 5'd0 || wr_drop !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL full_flush got cnt %0d drop %0h v%0h exp cnt 0 drop 0 v1", cnt(1), wr_drop, out_valid); end
        out_ready = 1'b1; tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain got %0h exp 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_push(3, mk(30 + i), 1'b0); tick();
        end
        checks++; if (cnt(3) !== 5'd4 || out_ch !== 2'd3 || out_desc !== mk(30)) begin
            errors++; $display("FAIL flush_setup got cnt %0d ch%0d %0h exp cnt 4 ch3 %0h", cnt(3), out_ch, out_desc, mk(30)); end
        set_push(0, mk(40), 1'b1); tick();
        clr_push(); flush = 4'b1000; tick();
        flush = '0;
        checks++; if (cnt(3) !== 5'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_drop got cnt %0d v%0h exp cnt 0 v0", cnt(3), out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_desc !== mk(40) || out_ch !== 2'd0) begin
            errors++; $display("FAIL flush_next got v%0h %0h ch%0d exp v1 %0h ch0", out_valid, out_desc, out_ch, mk(40)); end
        out_ready = 1'b1; tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_done got %0h exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_push(1, mk(50), 1'b0); tick();
        set_push(1, mk(51), 1'b0); tick();
        set_push(1, mk(52), 1'b1); tick();
        clr_push();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_desc !== mk(50) || out_ch !== 2'd1 || out_last !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got v%0h %0h ch%0d exp v1 %0h ch1", i, out_valid, out_desc, out_ch, mk(50)); end
        end
        out_ready = 1'b1; tick();
        checks++; if (out_valid !== 1'b1 || out_desc !== mk(51)) begin
            errors++; $display("FAIL bp_next got v%0h %0h exp v1 %0h", out_valid, out_desc, mk(51)); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_desc !== mk(52) || out_last !== 1'b1) begin
            errors++; $display("FAIL bp_last got v%0h %0h l%0h exp v1 %0h l1", out_valid, out_desc, out_last, mk(52)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_done got %0h exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_push(0, mk(60), 1'b0); tick();
        set_push(1, mk(61), 1'b0); tick();
        set_push(2, mk(62), 1'b1); tick();
        set_push(0, mk(63), 1'b1); tick();
        clr_push();
        checks++; if (empty !== 4'b1000 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_setup got empty %0h v%0h exp 8 v1", empty, out_valid); end
        rst = 1'b1; tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_desc !== 96'h0 || out_ch !== 2'd0 || out_last !== 1'b0) begin
            errors++; $display("FAIL rmid_out got v%0h %0h ch%0d l%0h exp all 0", out_valid, out_desc, out_ch, out_last); end
        checks++; if (count !== 20'h0 || empty !== 4'hF || full !== 4'h0 || afull !== 4'h0 || wr_drop !== 1'b0) begin
            errors++; $display("FAIL rmid_status got cnt %0h e%0h f%0h af%0h d%0h exp 0 f 0 0 0", count, empty, full, afull, wr_drop); end
        out_ready = 1'b1;
        set_push(0, mk(70), 1'b1); tick();
        clr_push();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_lat1 got %0h exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_desc !== mk(70) || out_ch !== 2'd0) begin
            errors++; $display("FAIL rmid_push got v%0h %0h ch%0d exp v1 %0h ch0", out_valid, out_desc, out_ch, mk(70)); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_full_drop();
        test_flush();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
